// File: rtl/an_code_pkg.sv
// Shared constants and FSM state type for the AN (A = 83) code path.
// The SEC location decoder imports the same constants.
package an_code_pkg;

    localparam int unsigned AN_A   = 83;
    localparam int unsigned R_W    = 7;
    localparam int unsigned DATA_W = 28;
    localparam int unsigned CW_W   = 35;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/an_mod_step.sv
// One MSB-first residue step: (2*acc + b) mod AN_A, purely combinational.
// With acc < AN_A the sum is below 2*AN_A, so one conditional subtract suffices.
module an_mod_step #(
    parameter int unsigned AN_A = 83,
    parameter int unsigned R_W  = 7
) (
    input  logic [R_W-1:0] acc,
    input  logic           b,
    output logic [R_W-1:0] nxt
);

    localparam logic [R_W:0] A_T = (R_W+1)'(AN_A);

    logic [R_W:0] t;
    logic [R_W:0] t_sub;

    always_comb begin
        t     = {acc, b};
        t_sub = t - A_T;
        if (t >= A_T) begin
            nxt = t_sub[R_W-1:0];
        end else begin
            nxt = t[R_W-1:0];
        end
    end

endmodule

// File: rtl/an_residue_serial.sv
// Bit-serial residue generator: r = y mod AN_A, one codeword bit per cycle,
// MSB first. The codeword is rotated back into place and presented with r.
module an_residue_serial #(
    parameter int unsigned CW_W = an_code_pkg::CW_W,
    parameter int unsigned AN_A = an_code_pkg::AN_A,
    parameter int unsigned R_W  = an_code_pkg::R_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW_W-1:0] in_cw,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [R_W-1:0]  out_r,
    output logic            out_zero,
    output logic [CW_W-1:0] out_cw
);

    import an_code_pkg::*;

    localparam int unsigned CNT_W = $clog2(CW_W);

    state_t            state;
    state_t            state_nxt;
    logic [CW_W-1:0]   sh;
    logic [R_W-1:0]    acc;
    logic [R_W-1:0]    acc_nxt;
    logic              zero;
    logic [CNT_W-1:0]  cnt;

    an_mod_step #(
        .AN_A (AN_A),
        .R_W  (R_W)
    ) u_step (
        .acc (acc),
        .b   (sh[CW_W-1]),
        .nxt (acc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid)    state_nxt = RUN;
            RUN:  if (cnt == '0)   state_nxt = DONE;
            DONE: if (out_ready)   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Full rotation over CW_W cycles leaves sh holding the original codeword.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh   <= '0;
            acc  <= '0;
            zero <= 1'b1;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh   <= in_cw;
                        acc  <= '0;
                        zero <= 1'b1;
                        cnt  <= CNT_W'(CW_W - 1);
                    end
                end
                RUN: begin
                    sh   <= {sh[CW_W-2:0], sh[CW_W-1]};
                    acc  <= acc_nxt;
                    zero <= (acc_nxt == '0);
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_r    = acc;
    assign out_zero = zero;
    assign out_cw   = sh;

endmodule

// File: tb/tb_an_residue_serial.sv
// Self-checking bench for an_residue_serial: directed residues, backpressure,
// streaming against an arithmetic y mod 83 reference, and async reset abort.
module tb_an_residue_serial;

    localparam int unsigned CW = 35;
    localparam int unsigned RW = 7;
    localparam longint      A  = 83;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_cw;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_r;
    logic          out_zero;
    logic [CW-1:0] out_cw;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    an_residue_serial #(
        .CW_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_zero  (out_zero),
        .out_cw    (out_cw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_mod(input longint y);
        return y % A;
    endfunction

    function automatic logic [CW-1:0] rand_cw();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[CW-1:0];
    endfunction

    // Accept y, wait for the result, optionally hold out_ready low, then release.
    task automatic run_word(input longint y, input int exp_r, input int hold, input bit noisy);
        int unsigned c0;
        bit          got;
        logic [63:0] yv;
        yv = y;
        @(negedge clk);
        chk("accept_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_cw     = yv[CW-1:0];
        out_ready = 1'b0;
        c0        = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_ready", in_ready, 0);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (out_valid) begin
                got = 1'b1;
            end else begin
                if (noisy) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_cw    = rand_cw();
                end
                @(negedge clk);
            end
        end
        if (!got) begin
            chk("out_valid_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        chk("latency", cyc - c0, 36);
        chk("out_r", out_r, exp_r);
        chk("out_zero", out_zero, (exp_r == 0));
        chk("out_cw", out_cw, yv[CW-1:0]);
        chk("done_ready", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1));
                in_cw    = rand_cw();
            end
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_r", out_r, exp_r);
            chk("hold_cw", out_cw, yv[CW-1:0]);
            chk("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", in_ready, 1);
        chk("release_valid", out_valid, 0);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_r"}, out_r, 0);
        chk({tag, "_out_zero"}, out_zero, 1);
        chk({tag, "_out_cw"}, out_cw, 0);
    endtask

    task automatic stream_test();
        longint      q[$];
        longint      words[20];
        longint      y;
        longint      e;
        longint      p;
        int unsigned last_acc;
        int          idx;
        int          n_out;
        for (int k = 0; k < 20; k++) begin
            y = A * longint'($urandom_range(1, 400000000));
            p = longint'(1) << $urandom_range(0, CW - 1);
            if ($urandom_range(0, 1) == 1 && y >= p) y = y - p;
            else if (y + p < (longint'(1) << CW)) y = y + p;
            else y = y - p;
            words[k] = y;
        end
        idx      = 0;
        n_out    = 0;
        last_acc = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 * 37 + 200 && n_out < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stream_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("stream_r", out_r, ref_mod(e));
                    chk("stream_zero", out_zero, (ref_mod(e) == 0));
                    chk("stream_cw", out_cw, e);
                end
                n_out++;
            end
            in_valid = (idx < 20);
            if (idx < 20) in_cw = words[idx][CW-1:0];
            if (in_ready && idx < 20) begin
                if (idx > 0) chk("stream_gap", cyc - last_acc, 37);
                last_acc = cyc;
                q.push_back(words[idx]);
                idx++;
            end
        end
        chk("stream_count", n_out, 20);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cw     = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_word(415, 0, 5, 1'b0);
        run_word(416, 1, 0, 1'b0);
        run_word(414, 82, 0, 1'b0);
        run_word(83 * 1000 + 1024, 28, 2, 1'b1);
        run_word(longint'(1) << 34, 59, 0, 1'b1);
        run_word((longint'(1) << 35) - 1, 34, 1, 1'b0);

        stream_test();

        // abort a word in cycle 10 of RUN
        @(negedge clk);
        in_valid = 1'b1;
        in_cw    = rand_cw();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_valid", out_valid, 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("abort_no_pulse", out_valid, 0);
        end
        run_word(416, 1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/an_residue_serial.md
# an_residue_serial

Bit-serial residue generator for the product (AN) code path with A = 83. It accepts one received codeword per handshake and computes r = y mod 83 MSB-first, one bit per cycle. It then presents r, a zero-syndrome flag and the unmodified codeword downstream. It sits directly upstream of the SEC location decoder, which maps r to a signed error location ±1..±41, and of the corrector.

## Interface
Parameters:
- CW_W, 35: codeword width in bits (28 data bits × A = 83 fits in 35 bits); legal range 8..41.
- AN_A, 83: AN-code multiplier. Fixed for the location table; not meant to be overridden.
- R_W, 7: residue width, ceil(log2(AN_A)).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream codeword valid.
- in_ready  out  1  block can accept a codeword.
- in_cw  in  CW_W  received codeword y, unsigned.
- out_valid  out  1  residue result valid.
- out_ready  in  1  downstream accepts the result.
- out_r  out  R_W  y mod AN_A, range 0..82.
- out_zero  out  1  asserted when out_r == 0 (no error detected).
- out_cw  out  CW_W  the codeword the residue belongs to, bit-exact copy of in_cw.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: load shift register ← in_cw, acc ← 0, cnt ← CW_W-1, go to RUN.
- **RUN**
  - in_ready = 0.
  - Each cycle: acc ← (2·acc + sh[CW_W-1]) mod AN_A. sh rotates left by 1, MSB into LSB.
  - When cnt == 0, go to DONE; otherwise cnt ← cnt-1.
- **DONE**
  - out_valid = 1.
  - After exactly CW_W rotations, sh equals the original codeword again; out_cw = sh.
  - On out_valid & out_ready, go to IDLE.
- Mod step arithmetic:
  - t = 2·acc + b, 8 bits wide, maximum 165.
  - Result is t-83 if t ≥ 83, else t. A single conditional subtract is sufficient.
  - acc always stays in 0..82.
- out_zero = (acc == 0), registered together with acc.
- in_ready is asserted only in IDLE. No accept in DONE, even when out_ready is high.
- Inputs in_valid/in_cw are ignored outside IDLE.
- Reset values:
  - state IDLE, acc 0, sh 0, cnt 0.
  - in_ready 1, out_valid 0, out_r 0, out_zero 1, out_cw 0.
- Reset asserted mid-RUN or mid-DONE aborts the word; nothing is emitted; state returns to IDLE.

## Timing
- Cycle 0: cycle in which in_valid & in_ready are sampled high.
- States by cycle:
  - Cycles 1..CW_W: RUN.
  - From cycle CW_W+1: out_valid high (cycle 36 for the default).
- out_r, out_zero and out_cw are stable for the whole time out_valid is high. out_valid stays high until the handshake.
- The cycle after the output handshake is IDLE with in_ready = 1.
- Minimum interval between accepts: CW_W+2 cycles.
- The output handshake is combinationally independent of the input side. There are no combinational paths from in_* to out_*.

## Structure
- Shared package an_code_pkg holds AN_A = 83, R_W = 7, DATA_W = 28, CW_W = 35, and the FSM state enum. The SEC location decoder imports the same constants.
- One sub-module: an_mod_step, purely combinational.
  - Inputs: acc[R_W-1:0], b.
  - Output: (2·acc+b) mod AN_A.
  - Reusable later for a 2- or 4-bit-per-cycle variant.

## Test plan
- **Multiples of A:** y = 415 (83·5).
  - out_r = 0, out_zero = 1, out_cw = 415.
  - out_valid first high in cycle 36.
- **Single-bit errors:**
  - y = 416 → r = 1.
  - y = 414 → r = 82.
  - y = 83·1000 + 2^10 → r = 28.
  - y = 2^34 → r = 59.
  - y = 2^35-1 → r = 34.
  - out_zero = 0 in every case.
- **Backpressure:**
  - Hold out_ready = 0 for 5 cycles after out_valid rises. out_r, out_cw and out_valid must be held, and in_ready must be 0 throughout.
  - Release out_ready: in_ready = 1 in the next cycle.
- **Back-to-back streaming:**
  - Apply in_valid continuously with 20 random multiples of 83 plus random ±2^i (i < 35), out_ready always 1.
  - Each out_r must match a golden y mod 83. Accepts are spaced exactly 37 cycles apart.
- **Async reset mid-RUN:**
  - Assert rst in cycle 10 of a word. All outputs immediately take their reset values and no out_valid pulse occurs.
  - The next word, y = 416, completes with r = 1.
- **Input ignored while busy:** toggle in_valid and change in_cw during RUN and DONE. The result for the accepted word must be unaffected.
